// File: rtl/dual_seq_gen.sv
// rtl/dual_seq_gen.sv - two-pattern serial sequence generator with repeat, hold and abort
// Streams pattern A (10001) or B (001100) MSB first, RPT+1 times back-to-back.
module dual_seq_gen #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       START,
    input  logic       SEL,
    input  logic [3:0] RPT,
    input  logic       HOLD,
    input  logic       ABORT,
    output logic       X,
    output logic       VALID,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_rep;
    logic       r_sel;
    logic [3:0] r_rpt;
    logic       r_x;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_last;
    logic [2:0] w_next_idx;

    // Bit idx counts from the leftmost (first transmitted) pattern bit.
    function automatic logic pat_bit(input logic sel, input logic [2:0] idx);
        if (sel)
            return (idx == 3'd2) || (idx == 3'd3);
        else
            return (idx == 3'd0) || (idx == 3'd4);
    endfunction

    assign w_last     = r_sel ? (r_idx == 3'd5) : (r_idx == 3'd4);
    assign w_next_idx = r_idx + 3'd1;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_rep   <= 4'd0;
            r_sel   <= 1'b0;
            r_rpt   <= 4'd0;
            r_x     <= IDLE_LEVEL;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ABORT) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_rep   <= 4'd0;
            r_x     <= IDLE_LEVEL;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // DONE is a single-cycle pulse even if HOLD is raised during it.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START && !HOLD) begin
                        r_state <= S_SEND;
                        r_sel   <= SEL;
                        r_rpt   <= RPT;
                        r_idx   <= 3'd0;
                        r_rep   <= 4'd0;
                        r_x     <= pat_bit(SEL, 3'd0);
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!HOLD) begin
                        if (w_last) begin
                            if (r_rep == r_rpt) begin
                                r_state <= S_IDLE;
                                r_idx   <= 3'd0;
                                r_rep   <= 4'd0;
                                r_x     <= IDLE_LEVEL;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_rep <= r_rep + 4'd1;
                                r_idx <= 3'd0;
                                r_x   <= pat_bit(r_sel, 3'd0);
                            end
                        end else begin
                            r_idx <= w_next_idx;
                            r_x   <= pat_bit(r_sel, w_next_idx);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign X     = r_x;
    assign VALID = r_valid;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_dual_seq_gen.sv
// tb/tb_dual_seq_gen.sv - directed self-checking bench for dual_seq_gen
module tb_dual_seq_gen;

    localparam logic IDLE = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [3:0] rpt;
    logic       hold;
    logic       abort;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;

    int n_run  = 0;
    int n_fail = 0;

    dual_seq_gen #(.IDLE_LEVEL(IDLE)) dut (
        .clk   (clk),
        .RST   (rst),
        .START (start),
        .SEL   (sel),
        .RPT   (rpt),
        .HOLD  (hold),
        .ABORT (abort),
        .X     (x),
        .VALID (valid),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_async x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b000});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_release x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b000});
        end
    endtask

    task automatic test_pattern_a();
        logic [4:0] exp;
        exp   = 5'b10001;
        start = 1'b1; sel = 1'b0; rpt = 4'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if ({x, valid, busy, done} !== {exp[4-i], 3'b110}) begin
                n_fail++;
                $display("FAIL pattern_a bit%0d x/valid/busy/done=%b required %b", i, {x, valid, busy, done}, {exp[4-i], 3'b110});
            end
            @(negedge clk);
        end
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b001}) begin
            n_fail++;
            $display("FAIL pattern_a_done x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b001});
        end
        @(negedge clk);
        n_run++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_a_done_width done=%b required 0", done);
        end
    endtask

    task automatic test_pattern_b_rpt();
        logic [11:0] exp;
        exp   = 12'b001100001100;
        start = 1'b1; sel = 1'b1; rpt = 4'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_run++;
            if ({x, valid, busy, done} !== {exp[11-i], 3'b110}) begin
                n_fail++;
                $display("FAIL pattern_b bit%0d x/valid/busy/done=%b required %b", i, {x, valid, busy, done}, {exp[11-i], 3'b110});
            end
            @(negedge clk);
        end
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b001}) begin
            n_fail++;
            $display("FAIL pattern_b_done x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b001});
        end
        @(negedge clk);
        n_run++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL pattern_b_single_done done=%b required 0", done);
        end
    endtask

    task automatic test_hold();
        logic [7:0] exp;
        exp = 8'b10000001;
        // HOLD in IDLE must block acceptance.
        hold = 1'b1; start = 1'b1; sel = 1'b0; rpt = 4'd0;
        @(negedge clk);
        n_run++;
        if ({valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_idle_blocks valid/busy=%b required 00", {valid, busy});
        end
        hold = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_run++;
            if ({x, valid, busy, done} !== {exp[7-i], 3'b110}) begin
                n_fail++;
                $display("FAIL hold_stream cyc%0d x/valid/busy/done=%b required %b", i, {x, valid, busy, done}, {exp[7-i], 3'b110});
            end
            if (i == 2) hold = 1'b1;
            if (i == 5) hold = 1'b0;
            @(negedge clk);
        end
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b001}) begin
            n_fail++;
            $display("FAIL hold_done x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b001});
        end
        // HOLD raised during the DONE cycle must not stretch DONE.
        hold = 1'b1;
        @(negedge clk);
        hold = 1'b0;
        n_run++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_done_not_extended done=%b required 0", done);
        end
    endtask

    task automatic test_abort();
        logic [11:0] exp;
        exp   = 12'b001100001100;
        start = 1'b1; sel = 1'b1; rpt = 4'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_run++;
            if ({x, valid, busy} !== {exp[11-i], 2'b11}) begin
                n_fail++;
                $display("FAIL abort_pre bit%0d x/valid/busy=%b required %b", i, {x, valid, busy}, {exp[11-i], 2'b11});
            end
            if (i == 7) begin
                abort = 1'b1;
                hold  = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0; hold = 1'b0;
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL abort_idle x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b000});
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_run++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_no_done cyc%0d busy/done=%b required 00", i, {busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        exp   = 5'b10001;
        start = 1'b1; sel = 1'b0; rpt = 4'd0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if ({x, valid, busy} !== {exp[4-i], 2'b11}) begin
                n_fail++;
                $display("FAIL b2b_first bit%0d x/valid/busy=%b required %b", i, {x, valid, busy}, {exp[4-i], 2'b11});
            end
            if (i == 1) begin
                sel = 1'b1;
                rpt = 4'd7;
            end
            if (i == 3) begin
                sel = 1'b0;
                rpt = 4'd0;
            end
            @(negedge clk);
        end
        n_run++;
        if ({valid, busy, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_done valid/busy/done=%b required 001", {valid, busy, done});
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if ({x, valid, busy, done} !== {exp[4-i], 3'b110}) begin
                n_fail++;
                $display("FAIL b2b_second bit%0d x/valid/busy/done=%b required %b", i, {x, valid, busy, done}, {exp[4-i], 3'b110});
            end
            @(negedge clk);
        end
        n_run++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_done done=%b required 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start = 1'b1; sel = 1'b1; rpt = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_run++;
        if ({x, valid, busy, done} !== {IDLE, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset x/valid/busy/done=%b required %b", {x, valid, busy, done}, {IDLE, 3'b000});
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_run++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL async_reset_no_done cyc%0d busy/done=%b required 00", i, {busy, done});
            end
        end
        start = 1'b1; sel = 1'b0; rpt = 4'd0;
        @(negedge clk);
        start = 1'b0;
        n_run++;
        if ({x, valid, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL restart_after_reset x/valid/busy=%b required 111", {x, valid, busy});
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; rpt = 4'd0; hold = 1'b0; abort = 1'b0;
        test_reset();
        test_pattern_a();
        test_pattern_b_rpt();
        test_hold();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
